// File: rtl/telemetry_framer_if.sv
// Sample-in / byte-out bus of the telemetry framer.
// The master side drives samples and byte_ready; the slave side is the framer.
interface telemetry_framer_if #(
    parameter int unsigned SAMPLE_WIDTH = 48
);
    logic                    sample_valid;
    logic [SAMPLE_WIDTH-1:0] sample_in;
    logic                    enable;
    logic                    byte_ready;
    logic                    byte_valid;
    logic [7:0]              byte_out;
    logic                    busy;
    logic [7:0]              overflow_count;

    modport master (
        output sample_valid, sample_in, enable, byte_ready,
        input  byte_valid, byte_out, busy, overflow_count
    );

    modport slave (
        input  sample_valid, sample_in, enable, byte_ready,
        output byte_valid, byte_out, busy, overflow_count
    );
endinterface

// File: rtl/telemetry_framer.sv
// Buffers packed telemetry samples in a small FIFO and serialises each one into
// a sync / seq / payload (MSB first) / checksum byte frame for the UART transmitter.
module telemetry_framer #(
    parameter int unsigned SAMPLE_WIDTH = 48,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    telemetry_framer_if.slave bus
);
    localparam int unsigned P     = SAMPLE_WIDTH / 8;
    localparam int unsigned IDX_W = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, SYNC, SEQ, PAYLOAD, CHECK} state_t;

    state_t                  r_state, w_state_next;
    logic [SAMPLE_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]        r_count, w_count_next;
    logic [SAMPLE_WIDTH-1:0] r_shift, w_shift_next;
    logic [IDX_W-1:0]        r_idx, w_idx_next;
    logic [7:0]              r_csum, w_csum_next;
    logic [7:0]              r_seq, w_seq_next;
    logic [7:0]              r_byte_out, w_byte_out_next;
    logic                    r_byte_valid, w_byte_valid_next;
    logic                    r_busy;
    logic [7:0]              r_ovf;
    logic                    w_empty, w_full, w_pop, w_push, w_drop, w_accept;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_accept = r_byte_valid && bus.byte_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign w_push   = bus.sample_valid && bus.enable && (!w_full || w_pop);
    assign w_drop   = bus.sample_valid && bus.enable && w_full && !w_pop;

    always_comb begin
        unique case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Frame sequencer: next-state and next-datapath values.
    always_comb begin
        w_state_next      = r_state;
        w_shift_next      = r_shift;
        w_idx_next        = r_idx;
        w_csum_next       = r_csum;
        w_seq_next        = r_seq;
        w_byte_out_next   = r_byte_out;
        w_byte_valid_next = r_byte_valid;
        w_pop             = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop             = 1'b1;
                    w_shift_next      = r_mem[r_rd_ptr];
                    w_byte_out_next   = SYNC_BYTE;
                    w_byte_valid_next = 1'b1;
                    w_state_next      = SYNC;
                end
            end
            SYNC: begin
                if (w_accept) begin
                    w_byte_out_next = r_seq;
                    w_state_next    = SEQ;
                end
            end
            SEQ: begin
                if (w_accept) begin
                    w_csum_next     = r_seq;
                    w_byte_out_next = r_shift[SAMPLE_WIDTH-1 -: 8];
                    w_shift_next    = r_shift << 8;
                    w_idx_next      = '0;
                    w_state_next    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (w_accept) begin
                    w_csum_next = r_csum + r_byte_out;
                    if (r_idx == IDX_W'(P - 1)) begin
                        w_byte_out_next = r_csum + r_byte_out;
                        w_state_next    = CHECK;
                    end else begin
                        w_byte_out_next = r_shift[SAMPLE_WIDTH-1 -: 8];
                        w_shift_next    = r_shift << 8;
                        w_idx_next      = r_idx + IDX_W'(1);
                    end
                end
            end
            CHECK: begin
                if (w_accept) begin
                    w_seq_next = r_seq + 8'd1;
                    // Back-to-back frames: load the next sample with no idle gap.
                    if (!w_empty) begin
                        w_pop             = 1'b1;
                        w_shift_next      = r_mem[r_rd_ptr];
                        w_byte_out_next   = SYNC_BYTE;
                        w_byte_valid_next = 1'b1;
                        w_state_next      = SYNC;
                    end else begin
                        w_byte_valid_next = 1'b0;
                        w_state_next      = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Sample storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.sample_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_shift      <= '0;
            r_idx        <= '0;
            r_csum       <= '0;
            r_seq        <= '0;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_ovf        <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count      <= w_count_next;
            r_shift      <= w_shift_next;
            r_idx        <= w_idx_next;
            r_csum       <= w_csum_next;
            r_seq        <= w_seq_next;
            r_byte_out   <= w_byte_out_next;
            r_byte_valid <= w_byte_valid_next;
            r_busy       <= (w_state_next != IDLE) || (w_count_next != '0);
            if (w_drop && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;
        end
    end

    assign bus.byte_valid     = r_byte_valid;
    assign bus.byte_out       = r_byte_out;
    assign bus.busy           = r_busy;
    assign bus.overflow_count = r_ovf;
endmodule

// File: tb/tb_telemetry_framer.sv
// Self-checking bench for telemetry_framer: byte scoreboard plus frame vector table.
module tb_telemetry_framer;
    logic clk;
    logic rst_n;

    telemetry_framer_if #(.SAMPLE_WIDTH(48)) bus ();

    telemetry_framer #(
        .SAMPLE_WIDTH(48),
        .FIFO_DEPTH  (4),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] sample;
        logic [7:0]  seq;
        logic [7:0]  csum;
        int          stall_at;
        int          stall_len;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;
    int         accepted = 0;
    logic [7:0] seq_m = 8'd0;
    logic       obs_valid, obs_busy;
    logic [7:0] obs_byte;
    logic       chk_gap = 1'b0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_csum(input logic [7:0] s, input logic [47:0] d);
        logic [7:0] c = s;
        for (int i = 0; i < 6; i++) c = c + d[47 - 8*i -: 8];
        return c;
    endfunction

    task automatic push_frame(input logic [7:0] s, input logic [47:0] d, input logic [7:0] c);
        exp_q.push_back(8'hA5);
        exp_q.push_back(s);
        for (int i = 0; i < 6; i++) exp_q.push_back(d[47 - 8*i -: 8]);
        exp_q.push_back(c);
    endtask

    // One clock: observe outputs at the falling edge, then return just after the rising edge.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        obs_valid = bus.byte_valid;
        obs_byte  = bus.byte_out;
        obs_busy  = bus.busy;
        if (rst_n && chk_gap && exp_q.size() != 0) chk("no_gap", obs_valid, 1'b1);
        if (rst_n && bus.byte_valid && bus.byte_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", bus.byte_out, 48'hFFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("frame_byte", bus.byte_out, e);
            end
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        bus.enable       = 1'b0;
        bus.byte_ready   = 1'b0;
        exp_q.delete();
        seq_m = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse(input logic [47:0] d);
        bus.sample_in    = d;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 48'(exp_q.size()), 48'd0);
            exp_q.delete();
        end
        tick();
        chk("idle_valid", obs_valid, 1'b0);
        chk("idle_busy", obs_busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{48'h0123456789AB, 8'h00, 8'h04, -1, 0};
        vecs[1] = '{48'h000000000000, 8'h01, 8'h01, -1, 0};
        vecs[2] = '{48'hFFFFFFFFFFFF, 8'h02, 8'hFC, -1, 0};
        vecs[3] = '{48'h010203040506, 8'h03, 8'h18, -1, 0};
        vecs[4] = '{48'h0123456789AB, 8'h04, 8'h08, 4, 10};

        // Reset state
        do_reset();
        chk("rst_valid", bus.byte_valid, 1'b0);
        chk("rst_byte", bus.byte_out, 8'h00);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ovf", bus.overflow_count, 8'h00);

        // Table-driven frames: latency, byte order, checksum, backpressure
        bus.enable     = 1'b1;
        bus.byte_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            accepted = 0;
            push_frame(vecs[v].seq, vecs[v].sample, vecs[v].csum);
            pulse(vecs[v].sample);
            tick();
            chk("lat_k1_valid", obs_valid, 1'b0);
            tick();
            chk("lat_k2_valid", obs_valid, 1'b1);
            chk("lat_k2_sync", obs_byte, 8'hA5);
            if (vecs[v].stall_at >= 0) begin
                for (int n = 0; n < 40 && accepted < vecs[v].stall_at; n++) tick();
                bus.byte_ready = 1'b0;
                for (int c = 0; c < vecs[v].stall_len; c++) begin
                    tick();
                    chk("stall_valid", obs_valid, 1'b1);
                    chk("stall_byte", obs_byte, exp_q[0]);
                end
                bus.byte_ready = 1'b1;
            end
            drain(40);
        end

        // Overflow: six back-to-back samples with the link stalled
        do_reset();
        bus.enable     = 1'b1;
        bus.byte_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [47:0] d = {16'($urandom), 32'($urandom)};
            if (i < 5) begin
                push_frame(seq_m, d, model_csum(seq_m, d));
                seq_m = seq_m + 8'd1;
            end
            bus.sample_in    = d;
            bus.sample_valid = 1'b1;
            tick();
        end
        bus.sample_valid = 1'b0;
        chk("ovf_count", bus.overflow_count, 8'd1);
        chk("ovf_busy", bus.busy, 1'b1);
        bus.byte_ready = 1'b1;
        chk_gap = 1'b1;
        drain(200);
        chk_gap = 1'b0;
        chk("ovf_hold", bus.overflow_count, 8'd1);

        // Enable gating: ignored samples, then enable dropped mid-frame
        do_reset();
        bus.byte_ready = 1'b1;
        bus.enable     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse(48'hDEAD_BEEF_0000 + 48'(i));
            tick();
            chk("en0_valid", obs_valid, 1'b0);
        end
        chk("en0_ovf", bus.overflow_count, 8'd0);
        chk("en0_busy", bus.busy, 1'b0);
        begin
            logic [47:0] d = 48'h1122_3344_5566;
            push_frame(seq_m, d, model_csum(seq_m, d));
            seq_m = seq_m + 8'd1;
            bus.enable = 1'b1;
            pulse(d);
            bus.enable = 1'b0;
            tick();
            tick();
            pulse(48'hABCD_EF01_2345);
            drain(40);
        end
        chk("en0_ovf_end", bus.overflow_count, 8'd0);

        // Sequence wrap over 257 frames against the checksum model
        do_reset();
        bus.enable     = 1'b1;
        bus.byte_ready = 1'b1;
        for (int f = 0; f < 257; f++) begin
            logic [47:0] d = {16'($urandom), 32'($urandom)};
            push_frame(seq_m, d, model_csum(seq_m, d));
            seq_m = seq_m + 8'd1;
            pulse(d);
            drain(40);
        end

        // Reset in the middle of a payload with samples queued
        do_reset();
        bus.enable     = 1'b1;
        bus.byte_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [47:0] d = {16'($urandom), 32'($urandom)};
            if (i < 5) begin
                push_frame(seq_m, d, model_csum(seq_m, d));
                seq_m = seq_m + 8'd1;
            end
            bus.sample_in    = d;
            bus.sample_valid = 1'b1;
            tick();
        end
        bus.sample_valid = 1'b0;
        chk("mid_ovf_pre", bus.overflow_count, 8'd1);
        accepted = 0;
        bus.byte_ready = 1'b1;
        for (int n = 0; n < 40 && accepted < 5; n++) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.byte_valid, 1'b0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_ovf", bus.overflow_count, 8'd0);
        exp_q.delete();
        seq_m = 8'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", obs_valid, 1'b0);
        chk("post_rst_busy", obs_busy, 1'b0);
        begin
            logic [47:0] d = 48'hCAFE_F00D_1234;
            push_frame(seq_m, d, model_csum(seq_m, d));
            seq_m = seq_m + 8'd1;
            pulse(d);
            drain(40);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
